// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_rx and uart_tx.
// Contents: the state encoding, the default line rate and clock frequency,
// and the clocks-per-bit helper.
package uart_pkg;

    localparam int BAUD_DEF = 115200;
    localparam int F_DEF    = 50_000_000;

    // The encoding is shared with uart_tx, so both blocks decode the same way.
    typedef enum logic [1:0] {
        START = 2'b00,
        DATA  = 2'b01,
        STOP  = 2'b10,
        IDLE  = 2'b11
    } uart_state_e;

    function automatic int clks_per_bit(input int f, input int baud);
        return f / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus from uart_rx to user logic.
//   data       : last received byte
//   data_valid : one-cycle strobe, data holds a new good frame
//   frame_err  : one-cycle strobe, stop bit was sampled 0
//   busy       : a frame is in progress
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (output data, data_valid, frame_err, busy);
    modport slave  (input  data, data_valid, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a serial line.
//   clk : destination clock
//   rst : async reset, active low
//   d   : asynchronous input
//   q   : synchronised output, 2 clk of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= 2'b11;
        else      ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Input: 1 start bit (0), 8 data bits LSB first,
// 1 stop bit (1), idle line high.
//   clk : system clock, rising edge
//   rst : async reset, active low
//   rx  : serial line, asynchronous to clk
//   bus : master side of uart_rx_if (data, data_valid, frame_err, busy)
// The start bit is checked at its midpoint, and every later bit is sampled one
// full bit period after that, so each sample lands near the centre of its bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD = BAUD_DEF,
    parameter int F    = F_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CPB  = clks_per_bit(F, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    logic            rx_s;
    uart_state_e     state, state_n;
    logic [CW-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      data_n;
    logic            dv_n, fe_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_n;
            clk_cnt        <= clk_cnt_n;
            bit_idx        <= bit_idx_n;
            shreg          <= shreg_n;
            bus.data       <= data_n;
            bus.data_valid <= dv_n;
            bus.frame_err  <= fe_n;
            // Registered from the next state so busy tracks state != IDLE exactly.
            bus.busy       <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = bus.data;
        dv_n      = 1'b0;
        fe_n      = 1'b0;

        unique case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) state_n = START;
            end

            START: begin
                if (clk_cnt == CNT_MID) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_n   = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n        = '0;
                    shreg_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end

            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    // Return to IDLE at mid-stop so a start bit that directly
                    // follows the stop bit is still caught.
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                    if (rx_s) begin
                        data_n = shreg;
                        dv_n   = 1'b1;
                    end else begin
                        fe_n   = 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
